imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV decode stage. It extracts and sign-extends the immediate for every base-ISA format (I, S, B, U, J) to XLEN bits and reports the format. A valid/ready handshake with a two-entry skid buffer lets the decode pipeline stall without losing instructions. It also keeps a saturating count of instructions whose opcode carries no immediate.

## Interface

- XLEN, 64: immediate width. Legal values are 32 or 64.
- TAG_W, 8: width of the sideband tag passed through with each instruction (PC index, ROB id, ...).
- SHIFT_BJ, 1: 1 gives byte offsets for B/J (LSB forced 0, 13/21-bit fields). 0 gives legacy halfword counts (B = sext of 12-bit field, J = sext of 20-bit field, no appended zero).
- ERR_W, 16: width of the unknown-opcode counter.

- clk, input, 1: single clock, rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: instr/in_tag are valid.
- in_ready, output, 1: block can accept this cycle.
- instr, input, 32: raw instruction word.
- in_tag, input, TAG_W: sideband tag.
- out_valid, output, 1: imm/fmt/out_tag are valid.
- out_ready, input, 1: consumer accepts this cycle.
- imm, output, XLEN: sign-extended immediate.
- fmt, output, 3: format code. 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_tag, output, TAG_W: tag of the instruction on the output.
- err_count, output, ERR_W: saturating count of accepted NONE-format instructions.

## Operation

Decode is on opcode = instr[6:0], done combinationally on the input, with the result registered.

- I-format opcodes: 0000011, 0010011, 0011011, 1100111, 0001111, 1110011. imm = sext(instr[31:20]).
- S-format opcode 0100011: imm = sext({instr[31:25], instr[11:7]}).
- B-format opcode 1100011: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}). With SHIFT_BJ=0 the trailing 0 is omitted.
- U-format opcodes 0110111, 0010111: imm = sext({instr[31:12], 12'b0}). This is sign-extended from bit 31 when XLEN=64.
- J-format opcode 1101111: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}). With SHIFT_BJ=0 the trailing 0 is omitted.
- Any other opcode: imm = 0, fmt = NONE.
- Sign extension always replicates instr[31].

Storage is a main output register (valid bit, imm, fmt, tag) plus one skid register of the same contents.

- in_ready = !skid_valid.
- The accept event is in_valid && in_ready. The drain event is out_valid && out_ready.
- Accept with the main register empty, or draining this cycle: the decoded word loads the main register.
- Accept while the main register is full and not draining: the word loads the skid register.
- Drain while the skid register is full: the skid contents move to the main register and the skid register empties. An accept in the same cycle is impossible, because in_ready = 0.
- Ordering is strictly FIFO. Outputs never change while out_valid && !out_ready.
- err_count increments by 1 on each accepted NONE instruction and saturates at 2^ERR_W − 1. It does not wrap.

## Timing

- Reset (rst_n = 0, asynchronous):
  - out_valid = 0, skid_valid = 0.
  - imm = 0, fmt = 0, out_tag = 0, err_count = 0.
  - in_ready = 1 during and after reset.
- Latency: an instruction accepted at edge N is on the outputs, with out_valid = 1, after edge N (next cycle) if nothing is ahead of it.
- Throughput: one instruction per cycle when out_ready is held high.
- Back-pressure:
  - With out_ready low, one more instruction is absorbed into the skid register.
  - in_ready then falls on the following cycle.
  - in_ready rises the cycle after the skid register drains.
- The producer must hold instr and in_tag stable while in_valid && !in_ready. The block does not rely on this for correctness.
- Reset asserted mid-stream discards both entries immediately. err_count also clears.

## Test plan

- Reset, then single accepts (XLEN=64, SHIFT_BJ=1), out_ready=1:
  - 0xFFF00093 (addi −1) gives imm=0xFFFF_FFFF_FFFF_FFFF, fmt=1, one cycle later.
  - 0xFE112E23 (sw −4) gives imm=0xFFFF_FFFF_FFFF_FFFC, fmt=2.
- 0xFE000CE3 (beq −8):
  - SHIFT_BJ=1 gives imm=−8 (…FFF8), fmt=3.
  - SHIFT_BJ=0 gives imm=−4 (…FFFC).
- U/J formats:
  - 0x123450B7 gives imm=0x0000_0000_1234_5000.
  - 0x800000B7 gives imm=0xFFFF_FFFF_8000_0000 (XLEN=64) and 0x8000_0000 (XLEN=32).
  - 0x0010006F (jal +2048) gives imm=0x800, fmt=5.
- Back-pressure:
  - Stream 4 tagged words (tags 1..4) with out_ready=0 from cycle 2.
  - in_ready drops after the 2nd accept. Outputs hold tag 1 stable.
  - Release out_ready: tags 1,2,3,4 appear in order, with no loss or duplication.
- Unknown opcodes:
  - Send 0x0000007F three times: fmt=0, imm=0, err_count=3.
  - With ERR_W=2, send 5 such words: err_count stays at 3.
- Assert rst_n low while both entries are full: out_valid=0 and in_ready=1 immediately (asynchronous), err_count=0.

Source files
------------

// File: rtl/imm_gen_if.sv
// imm_gen_if: valid/ready bus between decode producer, immediate generator and consumer
interface imm_gen_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [2:0]       fmt;
  logic [TAG_W-1:0] out_tag;
  modport master (output in_valid, instr, in_tag, out_ready,
                  input  in_ready, out_valid, imm, fmt, out_tag);
  modport slave  (input  in_valid, instr, in_tag, out_ready,
                  output in_ready, out_valid, imm, fmt, out_tag);
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV immediate decoder with two-entry skid buffer and no-immediate counter
module imm_gen_pipe #(
  parameter int XLEN     = 64,
  parameter int TAG_W    = 8,
  parameter int SHIFT_BJ = 1,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_gen_if.slave         bus,
  output logic [ERR_W-1:0] err_count
);
  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
  logic [31:0]      w;
  logic             s;
  logic [31:0]      b32, j32, d32;
  logic [2:0]       d_fmt;
  logic [XLEN-1:0]  d_imm;
  logic             out_v, skid_v, acc, drn;
  logic [XLEN-1:0]  m_imm, s_imm;
  logic [2:0]       m_fmt, s_fmt;
  logic [TAG_W-1:0] m_tag, s_tag;
  assign w             = bus.instr;
  assign s             = w[31];
  assign acc           = bus.in_valid && !skid_v;
  assign drn           = out_v && bus.out_ready;
  assign bus.in_ready  = !skid_v;
  assign bus.out_valid = out_v;
  assign bus.imm       = m_imm;
  assign bus.fmt       = m_fmt;
  assign bus.out_tag   = m_tag;
  // decode the incoming word to a 32-bit signed immediate, then widen by sign extension
  always_comb begin
    b32 = SHIFT_BJ != 0 ? {{19{s}}, w[31], w[7], w[30:25], w[11:8], 1'b0}
                        : {{20{s}}, w[31], w[7], w[30:25], w[11:8]};
    j32 = SHIFT_BJ != 0 ? {{11{s}}, w[31], w[19:12], w[20], w[30:21], 1'b0}
                        : {{12{s}}, w[31], w[19:12], w[20], w[30:21]};
    d_fmt = F_NONE;
    d32   = '0;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        d_fmt = F_I;
        d32   = {{20{s}}, w[31:20]};
      end
      7'b0100011: begin
        d_fmt = F_S;
        d32   = {{20{s}}, w[31:25], w[11:7]};
      end
      7'b1100011: begin
        d_fmt = F_B;
        d32   = b32;
      end
      7'b0110111, 7'b0010111: begin
        d_fmt = F_U;
        d32   = {w[31:12], 12'b0};
      end
      7'b1101111: begin
        d_fmt = F_J;
        d32   = j32;
      end
      default: ;
    endcase
    d_imm = XLEN'($signed(d32));
  end
  // main/skid storage: skid refills main on drain, new words go to main when it frees up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      m_imm  <= '0;
      m_fmt  <= '0;
      m_tag  <= '0;
      s_imm  <= '0;
      s_fmt  <= '0;
      s_tag  <= '0;
    end else if (drn && skid_v) begin
      m_imm  <= s_imm;
      m_fmt  <= s_fmt;
      m_tag  <= s_tag;
      skid_v <= 1'b0;
    end else if (acc && (!out_v || drn)) begin
      out_v <= 1'b1;
      m_imm <= d_imm;
      m_fmt <= d_fmt;
      m_tag <= bus.in_tag;
    end else if (acc) begin
      skid_v <= 1'b1;
      s_imm  <= d_imm;
      s_fmt  <= d_fmt;
      s_tag  <= bus.in_tag;
    end else if (drn) begin
      out_v <= 1'b0;
    end
  end
  // saturating count of accepted words without an immediate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count <= '0;
    else if (acc && d_fmt == F_NONE && err_count != '1) err_count <= err_count + 1'b1;
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table and scoreboard checks of imm_gen_pipe across three parameter sets
module tb_imm_gen_pipe;
  typedef struct packed {
    logic [31:0] w;
    logic [7:0]  tag;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [31:0] e2;
    logic [2:0]  f;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = '0;
  logic [7:0]  tag = '0;
  logic [15:0] err0, err1;
  logic [1:0]  err2;
  int n_chk = 0, n_fail = 0, stalls = 0;
  logic [15:0] exp_err0 = '0;
  logic [1:0]  exp_err2 = '0;
  vec_t cur, q[$], tbl[10];
  int drained[$];
  logic hold_prev = 1'b0;
  logic [63:0] h_imm;
  logic [2:0]  h_fmt;
  logic [7:0]  h_tag;

  imm_gen_if #(.XLEN(64), .TAG_W(8)) if0 ();
  imm_gen_if #(.XLEN(64), .TAG_W(8)) if1 ();
  imm_gen_if #(.XLEN(32), .TAG_W(8)) if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.instr = instr;        assign if1.instr = instr;        assign if2.instr = instr;
  assign if0.in_tag = tag;         assign if1.in_tag = tag;         assign if2.in_tag = tag;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SHIFT_BJ(1), .ERR_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .err_count(err0));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SHIFT_BJ(0), .ERR_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .err_count(err1));
  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SHIFT_BJ(1), .ERR_W(2))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .err_count(err2));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference decode written as arithmetic on a sign-extended word: {fmt, imm64}
  function automatic logic [66:0] ref_dec(input logic [31:0] w, input bit sh);
    longint sx, v;
    logic [2:0] f;
    sx = longint'($signed(w));
    v = 0;
    f = 3'd0;
    case (w[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73: begin f = 3'd1; v = sx >>> 20; end
      7'h23: begin f = 3'd2; v = ((sx >>> 25) <<< 5) | longint'(w[11:7]); end
      7'h63: begin
        f = 3'd3;
        v = ((sx >>> 31) <<< 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
        if (!sh) v = v >>> 1;
      end
      7'h37, 7'h17: begin f = 3'd4; v = sx & ~64'hFFF; end
      7'h6F: begin
        f = 3'd5;
        v = ((sx >>> 31) <<< 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
        if (!sh) v = v >>> 1;
      end
      default: ;
    endcase
    return {f, v};
  endfunction

  function automatic vec_t mkvec(input logic [31:0] w, input logic [7:0] t);
    logic [66:0] r0, r1;
    r0 = ref_dec(w, 1'b1);
    r1 = ref_dec(w, 1'b0);
    return '{w: w, tag: t, e0: r0[63:0], e1: r1[63:0], e2: r0[31:0], f: r0[66:64]};
  endfunction

  task automatic send(input vec_t v);
    cur = v;
    instr = v.w;
    tag = v.tag;
    in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (if0.in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_err0 = '0;
    exp_err2 = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // scoreboard monitor: compare on drain, push on accept, track holds and counters
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(if0.out_valid), 64'd1);
        check("hold_imm", if0.imm, h_imm);
        check("hold_tag", 64'(if0.out_tag), 64'(h_tag));
        check("hold_fmt", 64'(if0.fmt), 64'(h_fmt));
      end
      hold_prev <= if0.out_valid && !out_ready;
      h_imm <= if0.imm;
      h_fmt <= if0.fmt;
      h_tag <= if0.out_tag;
      check("err16", 64'(err0), 64'(exp_err0));
      check("err2", 64'(err2), 64'(exp_err2));
      if (in_valid && !if0.in_ready) stalls++;
      if (if0.out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 64'd0, 64'd1);
        else begin
          vec_t e;
          e = q.pop_front();
          drained.push_back(int'(e.tag));
          check("imm64", if0.imm, e.e0);
          check("imm64_bj0", if1.imm, e.e1);
          check("imm32", 64'(if2.imm), 64'(e.e2));
          check("fmt", 64'(if0.fmt), 64'(e.f));
          check("tag", 64'(if0.out_tag), 64'(e.tag));
          check("valid_bj0", 64'(if1.out_valid), 64'd1);
          check("valid32", 64'(if2.out_valid), 64'd1);
        end
      end
      if (in_valid && if0.in_ready) begin
        q.push_back(cur);
        if (cur.f == 3'd0) begin
          exp_err0 = exp_err0 + 16'd1;
          exp_err2 = (exp_err2 == 2'd3) ? 2'd3 : exp_err2 + 2'd1;
        end
      end
    end
  end

  initial begin
    logic [6:0] ops[12];
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    tbl[0] = '{32'hFFF00093, 8'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1};
    tbl[1] = '{32'hFE112E23, 8'd11, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd2};
    tbl[2] = '{32'hFE000CE3, 8'd12, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFF8, 3'd3};
    tbl[3] = '{32'h123450B7, 8'd13, 64'h0000_0000_1234_5000, 64'h0000_0000_1234_5000, 32'h1234_5000, 3'd4};
    tbl[4] = '{32'h800000B7, 8'd14, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4};
    tbl[5] = '{32'h0010006F, 8'd15, 64'h800, 64'h400, 32'h800, 3'd5};
    tbl[6] = '{32'h0000007F, 8'd16, 64'h0, 64'h0, 32'h0, 3'd0};
    tbl[7] = '{32'h7FF02083, 8'd17, 64'h7FF, 64'h7FF, 32'h7FF, 3'd1};
    tbl[8] = '{32'hFFFFF0B7, 8'd18, 64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_F000, 32'hFFFF_F000, 3'd4};
    tbl[9] = '{32'h00000013, 8'd19, 64'h0, 64'h0, 32'h0, 3'd1};
    #2;
    check("rst_in_ready", 64'(if0.in_ready), 64'd1);
    check("rst_out_valid", 64'(if0.out_valid), 64'd0);
    check("rst_imm", if0.imm, 64'd0);
    check("rst_fmt", 64'(if0.fmt), 64'd0);
    check("rst_tag", 64'(if0.out_tag), 64'd0);
    check("rst_err", 64'(err0), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i]);
      if (i == 0) begin
        check("latency_valid", 64'(if0.out_valid), 64'd1);
        check("latency_imm", if0.imm, tbl[0].e0);
      end
    end
    repeat (3) @(posedge clk);
    #1 stalls = 0;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      send(mkvec(w, 8'(i + 32)));
    end
    check("throughput_stalls", 64'(stalls), 64'd0);
    repeat (3) @(posedge clk);
    #1 drained.delete();
    out_ready = 1'b0;
    fork
      for (int t = 1; t <= 4; t++) send(mkvec(32'h00100093 + 32'(t << 20), 8'(t)));
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready", 64'(if0.in_ready), 64'd0);
        check("bp_out_valid", 64'(if0.out_valid), 64'd1);
        check("bp_out_tag", 64'(if0.out_tag), 64'd1);
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("bp_count", 64'(drained.size()), 64'd4);
    for (int t = 0; t < 4 && t < drained.size(); t++) check("bp_order", 64'(drained[t]), 64'(t + 1));
    check("bp_empty", 64'(q.size()), 64'd0);
    do_reset();
    for (int i = 0; i < 3; i++) send(tbl[6]);
    repeat (2) @(posedge clk);
    #1;
    check("none_err16", 64'(err0), 64'd3);
    check("none_err2", 64'(err2), 64'd3);
    for (int i = 0; i < 2; i++) send(tbl[6]);
    repeat (2) @(posedge clk);
    #1;
    check("sat_err16", 64'(err0), 64'd5);
    check("sat_err2", 64'(err2), 64'd3);
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    check("full_in_ready", 64'(if0.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(if0.out_valid), 64'd0);
    check("arst_in_ready", 64'(if0.in_ready), 64'd1);
    check("arst_err", 64'(err0), 64'd0);
    check("arst_valid32", 64'(if2.out_valid), 64'd0);
    q.delete();
    exp_err0 = '0;
    exp_err2 = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(tbl[3]);
    repeat (3) @(posedge clk);
    #1;
    check("final_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
